// File: rtl/el2_dec_gpr_wb_arb.sv
// Write-back arbiter in front of the 3-write-port GPR file: requester 0 owns port 0,
// long-latency requesters are staged one entry deep and round-robined onto ports 1 and 2.
module el2_dec_gpr_wb_arb #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wen0,
    output logic                 wen1,
    output logic                 wen2,
    output logic [4:0]           waddr0,
    output logic [4:0]           waddr1,
    output logic [4:0]           waddr2,
    output logic [31:0]          wd0,
    output logic [31:0]          wd1,
    output logic [31:0]          wd2,
    output logic [31:0]          pend_mask,
    output logic                 idle
);

    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] r_stage_v;
    logic [4:0]      r_stage_addr [NREQ];
    logic [31:0]     r_stage_data [NREQ];
    logic [PW-1:0]   r_rr_ptr;

    logic            r_wen0, r_wen1, r_wen2;
    logic [4:0]      r_waddr0, r_waddr1, r_waddr2;
    logic [31:0]     r_wd0, r_wd1, r_wd2;

    logic            w_req0_hit;
    logic            w_p1_v, w_p2_v;
    logic [PW-1:0]   w_p1_idx, w_p2_idx;
    logic [4:0]      w_p1_addr, w_p2_addr;
    logic [31:0]     w_p1_data, w_p2_data;
    logic [NREQ-1:0] w_clear;
    logic [PW-1:0]   w_rr_nxt;
    logic [31:0]     w_pend;

    function automatic logic [PW-1:0] rr_after(input logic [PW-1:0] idx);
        if (idx == PW'(NREQ - 1)) begin
            rr_after = PW'(1);
        end else begin
            rr_after = idx + PW'(1);
        end
    endfunction

    function automatic logic [31:0] dec_gpr(input logic [4:0] addr);
        dec_gpr = 32'd1 << addr;
    endfunction

    assign req_ready = ~r_stage_v | {{(NREQ-1){1'b0}}, 1'b1};

    // Round-robin scan of staged entries onto ports 1 and 2, avoiding same-GPR collisions
    always_comb begin
        logic [PW-1:0] idx;
        int            j;
        w_req0_hit = req_valid[0] & (req_addr[4:0] != 5'd0);
        w_p1_v     = 1'b0;
        w_p2_v     = 1'b0;
        w_p1_idx   = '0;
        w_p2_idx   = '0;
        w_p1_addr  = 5'd0;
        w_p2_addr  = 5'd0;
        w_p1_data  = 32'd0;
        w_p2_data  = 32'd0;
        w_clear    = '0;
        idx        = '0;
        j          = 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - (NREQ - 1);
            end else begin
                j = j;
            end
            idx = PW'(j);
            if (!r_stage_v[idx]) begin
                w_clear = w_clear;
            end else if (r_stage_addr[idx] == 5'd0) begin
                // writes to x0 vanish without taking a port or moving the pointer
                w_clear[idx] = 1'b1;
            end else if (w_req0_hit && (r_stage_addr[idx] == req_addr[4:0])) begin
                w_clear = w_clear;
            end else if (!w_p1_v) begin
                w_p1_v       = 1'b1;
                w_p1_idx     = idx;
                w_p1_addr    = r_stage_addr[idx];
                w_p1_data    = r_stage_data[idx];
                w_clear[idx] = 1'b1;
            end else if (!w_p2_v && (r_stage_addr[idx] != w_p1_addr)) begin
                w_p2_v       = 1'b1;
                w_p2_idx     = idx;
                w_p2_addr    = r_stage_addr[idx];
                w_p2_data    = r_stage_data[idx];
                w_clear[idx] = 1'b1;
            end else begin
                w_clear = w_clear;
            end
        end
    end

    // Pointer advances past the last granted requester
    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_p2_v) begin
            w_rr_nxt = rr_after(w_p2_idx);
        end else if (w_p1_v) begin
            w_rr_nxt = rr_after(w_p1_idx);
        end else begin
            w_rr_nxt = r_rr_ptr;
        end
    end

    // Stage capture/retire and round-robin pointer
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_stage_v <= '0;
            r_rr_ptr  <= PW'(1);
            for (int i = 0; i < NREQ; i++) begin
                r_stage_addr[i] <= 5'd0;
                r_stage_data[i] <= 32'd0;
            end
        end else begin
            r_rr_ptr     <= w_rr_nxt;
            r_stage_v[0] <= 1'b0;
            for (int i = 1; i < NREQ; i++) begin
                if (w_clear[i]) begin
                    r_stage_v[i] <= 1'b0;
                end else if (req_valid[i] && !r_stage_v[i]) begin
                    r_stage_v[i]    <= 1'b1;
                    r_stage_addr[i] <= req_addr[5*i +: 5];
                    r_stage_data[i] <= req_data[32*i +: 32];
                end else begin
                    r_stage_v[i] <= r_stage_v[i];
                end
            end
        end
    end

    // Registered write ports; addr/data are zeroed whenever the enable is low
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wen0   <= 1'b0;
            r_wen1   <= 1'b0;
            r_wen2   <= 1'b0;
            r_waddr0 <= 5'd0;
            r_waddr1 <= 5'd0;
            r_waddr2 <= 5'd0;
            r_wd0    <= 32'd0;
            r_wd1    <= 32'd0;
            r_wd2    <= 32'd0;
        end else begin
            r_wen0   <= w_req0_hit;
            r_waddr0 <= w_req0_hit ? req_addr[4:0] : 5'd0;
            r_wd0    <= w_req0_hit ? req_data[31:0] : 32'd0;
            r_wen1   <= w_p1_v;
            r_waddr1 <= w_p1_addr;
            r_wd1    <= w_p1_data;
            r_wen2   <= w_p2_v;
            r_waddr2 <= w_p2_addr;
            r_wd2    <= w_p2_data;
        end
    end

    // Pending-write mask from staged entries and in-flight port writes
    always_comb begin
        w_pend = 32'd0;
        for (int i = 1; i < NREQ; i++) begin
            if (r_stage_v[i]) begin
                w_pend = w_pend | dec_gpr(r_stage_addr[i]);
            end else begin
                w_pend = w_pend;
            end
        end
        if (r_wen0) begin
            w_pend = w_pend | dec_gpr(r_waddr0);
        end else begin
            w_pend = w_pend;
        end
        if (r_wen1) begin
            w_pend = w_pend | dec_gpr(r_waddr1);
        end else begin
            w_pend = w_pend;
        end
        if (r_wen2) begin
            w_pend = w_pend | dec_gpr(r_waddr2);
        end else begin
            w_pend = w_pend;
        end
    end

    assign pend_mask = w_pend & ~32'd1;
    assign idle      = ~(|r_stage_v) & ~r_wen0 & ~r_wen1 & ~r_wen2;

    assign wen0   = r_wen0;
    assign wen1   = r_wen1;
    assign wen2   = r_wen2;
    assign waddr0 = r_waddr0;
    assign waddr1 = r_waddr1;
    assign waddr2 = r_waddr2;
    assign wd0    = r_wd0;
    assign wd1    = r_wd1;
    assign wd2    = r_wd2;

endmodule

// File: tb/tb_el2_dec_gpr_wb_arb.sv
// Scoreboard bench for el2_dec_gpr_wb_arb: expected port writes are queued per port
// when stimulus is issued; a negedge monitor pops and compares every asserted wen.
module tb_el2_dec_gpr_wb_arb;

    localparam int NREQ = 4;

    logic                 clk;
    logic                 rst_l;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_addr;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wen0, wen1, wen2;
    logic [4:0]           waddr0, waddr1, waddr2;
    logic [31:0]          wd0, wd1, wd2;
    logic [31:0]          pend_mask;
    logic                 idle;

    int checks;
    int failures;

    logic [36:0] exp0 [$];
    logic [36:0] exp1 [$];
    logic [36:0] exp2 [$];

    el2_dec_gpr_wb_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wen0      (wen0),
        .wen1      (wen1),
        .wen2      (wen2),
        .waddr0    (waddr0),
        .waddr1    (waddr1),
        .waddr2    (waddr2),
        .wd0       (wd0),
        .wd1       (wd1),
        .wd2       (wd2),
        .pend_mask (pend_mask),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic mon_port(input int p, input logic [4:0] a, input logic [31:0] d);
        logic [36:0] e;
        checks++;
        if (p == 0 && exp0.size() > 0) begin
            e = exp0.pop_front();
        end else if (p == 1 && exp1.size() > 0) begin
            e = exp1.pop_front();
        end else if (p == 2 && exp2.size() > 0) begin
            e = exp2.pop_front();
        end else begin
            failures++;
            $display("FAIL port%0d_unexpected_write actual addr=%0d data=%h expected no write", p, a, d);
            return;
        end
        if ({a, d} !== e) begin
            failures++;
            $display("FAIL port%0d_write actual addr=%0d data=%h expected addr=%0d data=%h",
                     p, a, d, e[36:32], e[31:0]);
        end
    endtask

    // Monitor: every asserted wen must match the head of its port queue; no duplicate waddr
    always @(negedge clk) begin
        if (rst_l) begin
            if (wen0) mon_port(0, waddr0, wd0);
            if (wen1) mon_port(1, waddr1, wd1);
            if (wen2) mon_port(2, waddr2, wd2);
            if ((wen0 && wen1) || (wen0 && wen2) || (wen1 && wen2)) begin
                checks++;
                if ((wen0 && wen1 && waddr0 == waddr1) || (wen0 && wen2 && waddr0 == waddr2) ||
                    (wen1 && wen2 && waddr1 == waddr2)) begin
                    failures++;
                    $display("FAIL dup_waddr actual a0=%0d a1=%0d a2=%0d expected distinct",
                             waddr0, waddr1, waddr2);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_addr[5*i +: 5] = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    initial begin
        int          cnt [NREQ];
        int          lowrun [NREQ];
        int          maxlow;
        logic [NREQ-1:0] rdy;
        logic [4:0]  bp_addr [NREQ];
        logic [31:0] bp_base [NREQ];

        checks   = 0;
        failures = 0;
        rst_l    = 1'b0;
        clear_reqs();
        repeat (3) tick();

        // reset state
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_wen", 64'({wen0, wen1, wen2}), 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'hF);
        rst_l = 1'b1;
        tick();

        // req0 single write, one-cycle latency
        set_req(0, 1'b1, 5'd5, 32'hA5A5_0001);
        exp0.push_back({5'd5, 32'hA5A5_0001});
        tick();
        clear_reqs();
        chk("r0_idle_busy", 64'(idle), 64'd0);
        chk("r0_pend", 64'(pend_mask), 64'h20);
        tick();
        chk("r0_idle_after", 64'(idle), 64'd1);
        chk("r0_pend_after", 64'(pend_mask), 64'd0);

        // three staged requesters, round-robin over two ports
        set_req(1, 1'b1, 5'd7, 32'h1111_0007);
        set_req(2, 1'b1, 5'd8, 32'h2222_0008);
        set_req(3, 1'b1, 5'd9, 32'h3333_0009);
        exp1.push_back({5'd7, 32'h1111_0007});
        exp2.push_back({5'd8, 32'h2222_0008});
        exp1.push_back({5'd9, 32'h3333_0009});
        tick();
        clear_reqs();
        chk("rr_ready_t1", 64'(req_ready), 64'h1);
        tick();
        chk("rr_ready_t2", 64'(req_ready), 64'h7);
        chk("rr_pend_t2", 64'(pend_mask), 64'h380);
        tick();
        chk("rr_ready_t3", 64'(req_ready), 64'hF);
        chk("rr_pend_t3", 64'(pend_mask), 64'h200);
        tick();
        chk("rr_idle", 64'(idle), 64'd1);

        // conflict with req0 on GPR 10: stage1 waits, stage2 takes port 1
        set_req(1, 1'b1, 5'd10, 32'h1111_000A);
        set_req(2, 1'b1, 5'd11, 32'h2222_000B);
        tick();
        clear_reqs();
        set_req(0, 1'b1, 5'd10, 32'h0000_D00A);
        exp0.push_back({5'd10, 32'h0000_D00A});
        exp1.push_back({5'd11, 32'h2222_000B});
        exp1.push_back({5'd10, 32'h1111_000A});
        tick();
        clear_reqs();
        chk("cf_ready_hold", 64'(req_ready), 64'hD);
        tick();
        chk("cf_ready_free", 64'(req_ready), 64'hF);
        tick();

        // x0 writes are accepted and dropped
        set_req(0, 1'b1, 5'd0, 32'hDEAD_0000);
        set_req(2, 1'b1, 5'd0, 32'hDEAD_0002);
        tick();
        clear_reqs();
        chk("x0_ready_t1", 64'(req_ready), 64'hB);
        chk("x0_pend_t1", 64'(pend_mask), 64'd0);
        chk("x0_idle_t1", 64'(idle), 64'd0);
        tick();
        chk("x0_ready_t2", 64'(req_ready), 64'hF);
        chk("x0_pend_t2", 64'(pend_mask), 64'd0);
        chk("x0_idle_t2", 64'(idle), 64'd1);
        tick();

        // back-pressure: 4 values each from requesters 1..3, pointer starts at 2
        bp_addr[1] = 5'd12; bp_base[1] = 32'hA000_0000;
        bp_addr[2] = 5'd20; bp_base[2] = 32'hB000_0000;
        bp_addr[3] = 5'd21; bp_base[3] = 32'hC000_0000;
        for (int k = 0; k < 4; k++) begin
            exp1.push_back({5'd20, 32'hB000_0000 + 32'(k)});
            exp1.push_back({5'd12, 32'hA000_0000 + 32'(k)});
            exp2.push_back({5'd21, 32'hC000_0000 + 32'(k)});
        end
        maxlow = 0;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]    = 0;
            lowrun[i] = 0;
        end
        for (int n = 0; n < 30 && (cnt[1] < 4 || cnt[2] < 4 || cnt[3] < 4); n++) begin
            for (int i = 1; i < NREQ; i++) begin
                if (cnt[i] < 4) set_req(i, 1'b1, bp_addr[i], bp_base[i] + 32'(cnt[i]));
                else            set_req(i, 1'b0, 5'd0, 32'd0);
            end
            rdy = req_ready;
            for (int i = 1; i < NREQ; i++) begin
                if (!rdy[i]) lowrun[i]++;
                else         lowrun[i] = 0;
                if (lowrun[i] > maxlow) maxlow = lowrun[i];
            end
            tick();
            for (int i = 1; i < NREQ; i++) begin
                if (req_valid[i] && rdy[i]) cnt[i]++;
            end
        end
        clear_reqs();
        chk("bp_all_accepted", 64'(cnt[1] + cnt[2] + cnt[3]), 64'd12);
        chk("bp_max_wait_le3", 64'(maxlow <= 3), 64'd1);
        repeat (4) tick();
        chk("bp_idle", 64'(idle), 64'd1);

        // reset while wen1 and stage3 are live
        set_req(1, 1'b1, 5'd16, 32'h1111_0010);
        tick();
        clear_reqs();
        set_req(3, 1'b1, 5'd17, 32'h3333_0011);
        tick();
        clear_reqs();
        chk("mr_wen1_live", 64'(wen1), 64'd1);
        chk("mr_pend_live", 64'(pend_mask), 64'h0003_0000);
        rst_l = 1'b0;
        #1;
        chk("mr_wen_cleared", 64'({wen0, wen1, wen2}), 64'd0);
        chk("mr_wd1_cleared", 64'({waddr1, wd1}), 64'd0);
        chk("mr_idle", 64'(idle), 64'd1);
        chk("mr_pend", 64'(pend_mask), 64'd0);
        repeat (2) tick();
        rst_l = 1'b1;
        repeat (4) tick();
        chk("mr_idle_after", 64'(idle), 64'd1);

        chk("queues_drained", 64'(exp0.size() + exp1.size() + exp2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
